// File: rtl/lab3_converter_pkg.sv
// Shared definitions for the serial Excess-3 to BCD converter:
// state-register width and the 3-bit state encoding.
package lab3_converter_pkg;

    localparam int unsigned STATE_W = 3;

    // Bit position within a frame, with or without a pending borrow.
    // Encoding 3'b111 is unused and recovers to S0.
    typedef enum logic [STATE_W-1:0] {
        S0  = 3'b000,
        S1N = 3'b001,
        S1B = 3'b010,
        S2N = 3'b011,
        S2B = 3'b100,
        S3N = 3'b101,
        S3B = 3'b110
    } state_t;

endpackage

// File: rtl/lab3_converter_structure_dff.sv
// converter_dff: 1-bit D flip-flop with asynchronous active-low clear.
// Used as one bit of the converter's state register.
module converter_dff (
    input  logic i_d,
    input  logic Clk,
    input  logic Rst,
    output logic o_q
);

    logic r_q;

    // Capture D on the rising edge; clear immediately when Rst is low.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/lab3_converter_structure.sv
// lab3_converter_structure: bit-serial Excess-3 to BCD converter (Mealy FSM).
// Each 4-bit digit arrives LSB first on X; Z carries (digit - 3) mod 16 in the
// same cycle. The state register is three converter_dff instances, and the
// next-state/output logic is a set of sum-of-products equations.
// Optional build macro CONV_DIGIT_LAST_EN adds port Last, high on bit 3 of a frame.
module lab3_converter_structure
    import lab3_converter_pkg::*;
(
    input  logic X,
    input  logic Clk,
    input  logic Rst,
    output logic Z
`ifdef CONV_DIGIT_LAST_EN
    ,
    output logic Last
`endif
);

    logic [STATE_W-1:0] r_q;
    logic [STATE_W-1:0] w_d;
    logic               w_z;

    logic w_s0;
    logic w_s1n;
    logic w_s1b;
    logic w_s2n;
    logic w_s2b;
    logic w_s3n;

    converter_dff u_dff0 (
        .i_d (w_d[0]),
        .Clk (Clk),
        .Rst (Rst),
        .o_q (r_q[0])
    );

    converter_dff u_dff1 (
        .i_d (w_d[1]),
        .Clk (Clk),
        .Rst (Rst),
        .o_q (r_q[1])
    );

    converter_dff u_dff2 (
        .i_d (w_d[2]),
        .Clk (Clk),
        .Rst (Rst),
        .o_q (r_q[2])
    );

    // State decode, next-state and output equations. S3B and the unused code
    // contribute no product terms, so both fall to S0 with Z = ~X.
    always_comb begin
        w_s0  = (r_q == S0);
        w_s1n = (r_q == S1N);
        w_s1b = (r_q == S1B);
        w_s2n = (r_q == S2N);
        w_s2b = (r_q == S2B);
        w_s3n = (r_q == S3N);

        w_d = '0;
        w_z = ~X;

        w_d[2] = w_s1b | w_s2n | (w_s1n & ~X) | w_s2b;
        w_d[1] = (w_s0 & ~X) | (w_s1n & X) | (w_s2b & ~X);
        w_d[0] = (w_s0 & X) | (w_s1n & X) | w_s2n | (w_s2b & X);

        // X passes through where the borrow-in and subtrahend bit cancel,
        // otherwise it is inverted.
        w_z = X ^ ~(w_s1b | w_s2n | w_s3n);
    end

    assign Z = w_z;

`ifdef CONV_DIGIT_LAST_EN
    assign Last = (r_q == S3N) | (r_q == S3B);
`endif

endmodule

// File: tb/tb_lab3_converter_structure.sv
// Testbench for lab3_converter_structure: directed frames from the test plan
// followed by random digits with random mid-frame resets, checked against the
// arithmetic (digit - 3) mod 16.
module tb_lab3_converter_structure;

    logic X;
    logic Clk;
    logic Rst;
    logic Z;
`ifdef CONV_DIGIT_LAST_EN
    logic Last;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    lab3_converter_structure dut (
        .X   (X),
        .Clk (Clk),
        .Rst (Rst),
        .Z   (Z)
`ifdef CONV_DIGIT_LAST_EN
        ,
        .Last(Last)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Feed the low nbits of digit d, LSB first. Entered just after a rising
    // edge (or reset release); returns just after the edge consuming the last bit.
    task automatic send_digit(input int unsigned d, input int unsigned nbits);
        int unsigned e;
        logic        eb;
        logic        xb;
        e = (d + 16 - 3) % 16;
        for (int unsigned i = 0; i < nbits; i++) begin
            xb = ((d >> i) & 1) != 0;
            eb = ((e >> i) & 1) != 0;
            X = xb;
            @(negedge Clk);
            chk($sformatf("Z d=%0d bit=%0d", d, i), Z, eb);
`ifdef CONV_DIGIT_LAST_EN
            chk($sformatf("Last d=%0d bit=%0d", d, i), Last, (i == 3));
`endif
            @(posedge Clk);
            #1;
        end
    endtask

    // Short asynchronous reset pulse between edges.
    task automatic pulse_reset();
        Rst = 1'b0;
        #1;
        chk("Z in reset", Z, ~X);
`ifdef CONV_DIGIT_LAST_EN
        chk("Last in reset", Last, 1'b0);
`endif
        Rst = 1'b1;
    endtask

    initial begin
        int unsigned d;
        int unsigned k;

        Rst = 1'b0;
        X   = 1'b0;
        #2;
        chk("Z reset X=0", Z, 1'b1);
        X = 1'b1;
        #1;
        chk("Z reset X=1", Z, 1'b0);
`ifdef CONV_DIGIT_LAST_EN
        chk("Last reset", Last, 1'b0);
`endif
        @(posedge Clk);
        #1;
        chk("Z held in reset", Z, 1'b0);
        Rst = 1'b1;

        send_digit(4'b0011, 4);
        send_digit(4'b1100, 4);
        send_digit(4'b0111, 4);
        for (int unsigned v = 3; v <= 12; v++) begin
            send_digit(v, 4);
        end
        send_digit(4'b0000, 4);
        send_digit(4'b1000, 4);
        send_digit(4'b1111, 4);

        send_digit(4'b0101, 3);
        pulse_reset();
        send_digit(4'b1010, 4);

        for (int n = 0; n < 60; n++) begin
            d = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, 3);
                send_digit(d, k);
                pulse_reset();
            end else begin
                send_digit(d, 4);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
